bias_ctrl: RTL and testbench



---
 rtl/tpu_pkg.sv | 18 +
 rtl/bias_loader.sv | 62 ++++++
 rtl/bias_ctrl.sv | 106 ++++++++++
 tb/tb_bias_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types for the systolic-array edge blocks: bias scalar type and sequencer state encodings.
package tpu_pkg;

    localparam int unsigned DATA_W = 16;

    typedef logic signed [DATA_W-1:0] bias_t;

    typedef enum logic {
        L_FILL = 1'b0,
        L_FULL = 1'b1
    } load_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RUN  = 1'b1
    } run_state_e;

endpackage

// File: rtl/bias_loader.sv
// Bias stream to one-hot per-column load sequencer; owns the column index and the staged-set flag.
module bias_loader #(
    parameter int unsigned N_COLS = 2,
    parameter int unsigned DATA_W = tpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              b_valid_i,
    input  logic [DATA_W-1:0] b_data_i,
    input  logic              accept_i,
    output logic              b_ready_o,
    output logic [N_COLS-1:0] load_bias_o,
    output logic [DATA_W-1:0] bias_scalar_o,
    output logic              staged_full_o
);
    import tpu_pkg::*;

    localparam int unsigned      IDX_W    = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COLS - 1);

    load_state_e       state_q;
    logic [IDX_W-1:0]  load_idx_q;
    logic [N_COLS-1:0] load_bias_q;
    logic [DATA_W-1:0] scalar_q;
    logic              staged_full_q;
    logic              beat_c;

    // Held off during accept so no strobe can land in the switch cycle.
    assign b_ready_o = !rst && (state_q == L_FILL) && !accept_i;
    assign beat_c    = b_valid_i && b_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= L_FILL;
            load_idx_q    <= '0;
            load_bias_q   <= '0;
            scalar_q      <= '0;
            staged_full_q <= 1'b0;
        end else begin
            load_bias_q <= '0;
            if (accept_i) begin
                state_q       <= L_FILL;
                staged_full_q <= 1'b0;
            end else if (beat_c) begin
                load_bias_q <= N_COLS'(1) << load_idx_q;
                scalar_q    <= b_data_i;
                if (load_idx_q == LAST_IDX) begin
                    load_idx_q    <= '0;
                    state_q       <= L_FULL;
                    staged_full_q <= 1'b1;
                end else begin
                    load_idx_q <= load_idx_q + IDX_W'(1);
                end
            end
        end
    end

    assign load_bias_o   = load_bias_q;
    assign bias_scalar_o = scalar_q;
    assign staged_full_o = staged_full_q;

endmodule

// File: rtl/bias_ctrl.sv
// Bias row sequencer: stages bias sets via bias_loader, switches them in at tile start and
// counts last-column valid beats to detect tile completion.
module bias_ctrl #(
    parameter int unsigned N_COLS = 2,
    parameter int unsigned DATA_W = tpu_pkg::DATA_W,
    parameter int unsigned ROWS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [DATA_W-1:0] b_data,
    input  logic              tile_start,
    output logic              tile_start_ready,
    input  logic [ROWS_W-1:0] tile_rows,
    input  logic              tile_backward,
    input  logic              col_valid_last_in,
    output logic [N_COLS-1:0] load_bias_out,
    output logic [DATA_W-1:0] bias_scalar_out,
    output logic              bias_switch_out,
    output logic              bias_backward_out,
    output logic              staged_full,
    output logic              running,
    output logic              tile_done,
    output logic              err_out
);
    import tpu_pkg::*;

    run_state_e        run_q;
    logic [ROWS_W-1:0] rows_q;
    logic [ROWS_W-1:0] cnt_q;
    logic              switch_q;
    logic              backward_q;
    logic              running_q;
    logic              done_q;
    logic              err_q;
    logic              accept_c;
    logic              last_beat_c;

    assign tile_start_ready = staged_full && (run_q == R_IDLE);
    assign accept_c         = tile_start && tile_start_ready;
    assign last_beat_c      = col_valid_last_in && (ROWS_W'(cnt_q + ROWS_W'(1)) == rows_q);

    bias_loader #(
        .N_COLS (N_COLS),
        .DATA_W (DATA_W)
    ) u_loader (
        .clk           (clk),
        .rst           (rst),
        .b_valid_i     (b_valid),
        .b_data_i      (b_data),
        .accept_i      (accept_c),
        .b_ready_o     (b_ready),
        .load_bias_o   (load_bias_out),
        .bias_scalar_o (bias_scalar_out),
        .staged_full_o (staged_full)
    );

    // Run FSM; a zero-row tile completes on the cycle after its switch without counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q      <= R_IDLE;
            rows_q     <= '0;
            cnt_q      <= '0;
            switch_q   <= 1'b0;
            backward_q <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            switch_q <= accept_c;
            done_q   <= 1'b0;
            if (col_valid_last_in && (run_q == R_IDLE)) begin
                err_q <= 1'b1;
            end
            case (run_q)
                R_IDLE: begin
                    if (accept_c) begin
                        run_q      <= R_RUN;
                        rows_q     <= tile_rows;
                        cnt_q      <= '0;
                        running_q  <= 1'b1;
                        backward_q <= tile_backward;
                    end
                end
                R_RUN: begin
                    if ((rows_q == '0) || last_beat_c) begin
                        run_q      <= R_IDLE;
                        done_q     <= 1'b1;
                        running_q  <= 1'b0;
                        backward_q <= 1'b0;
                    end else if (col_valid_last_in) begin
                        cnt_q <= cnt_q + ROWS_W'(1);
                    end
                end
            endcase
        end
    end

    assign bias_switch_out   = switch_q;
    assign bias_backward_out = backward_q;
    assign running           = running_q;
    assign tile_done         = done_q;
    assign err_out           = err_q;

endmodule

// File: tb/tb_bias_ctrl.sv
// Self-checking bench for bias_ctrl: directed scenario tasks plus a randomized run against a
// transaction-level model (beats staged, rows remaining).
module tb_bias_ctrl;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned RW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          b_valid;
    logic          b_ready;
    logic [DW-1:0] b_data;
    logic          tile_start;
    logic          tile_start_ready;
    logic [RW-1:0] tile_rows;
    logic          tile_backward;
    logic          col_valid_last_in;
    logic [N-1:0]  load_bias_out;
    logic [DW-1:0] bias_scalar_out;
    logic          bias_switch_out;
    logic          bias_backward_out;
    logic          staged_full;
    logic          running;
    logic          tile_done;
    logic          err_out;

    logic [N+DW+7:0] all_outs;
    logic [DW-1:0]   set_vals [4];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bias_ctrl #(.N_COLS(N), .DATA_W(DW), .ROWS_W(RW)) dut (
        .clk               (clk),
        .rst               (rst),
        .b_valid           (b_valid),
        .b_ready           (b_ready),
        .b_data            (b_data),
        .tile_start        (tile_start),
        .tile_start_ready  (tile_start_ready),
        .tile_rows         (tile_rows),
        .tile_backward     (tile_backward),
        .col_valid_last_in (col_valid_last_in),
        .load_bias_out     (load_bias_out),
        .bias_scalar_out   (bias_scalar_out),
        .bias_switch_out   (bias_switch_out),
        .bias_backward_out (bias_backward_out),
        .staged_full       (staged_full),
        .running           (running),
        .tile_done         (tile_done),
        .err_out           (err_out)
    );

    assign all_outs = {b_ready, tile_start_ready, load_bias_out, bias_scalar_out, bias_switch_out,
                       bias_backward_out, staged_full, running, tile_done, err_out};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b_valid = 1'b0; b_data = '0; tile_start = 1'b0; tile_rows = '0;
        tile_backward = 1'b0; col_valid_last_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_set();
        for (int i = 0; i < 4; i++) begin
            b_valid = 1'b1;
            b_data  = set_vals[i];
            tick();
        end
        b_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        n_tests++;
        if (all_outs !== '0) begin n_fail++; $display("FAIL reset_outs: got %h expected 0", all_outs); end
        rst = 1'b0;
        #1;
        n_tests++;
        if (b_ready !== 1'b1) begin n_fail++; $display("FAIL reset_bready: got %b expected 1", b_ready); end
    endtask

    task automatic test_basic_load();
        logic [N-1:0] exp_l;
        set_vals[0] = 16'h0100; set_vals[1] = 16'h0200; set_vals[2] = 16'hFF00; set_vals[3] = 16'h0080;
        for (int i = 0; i < 4; i++) begin
            b_valid = 1'b1;
            b_data  = set_vals[i];
            #1;
            n_tests++;
            if (b_ready !== 1'b1) begin n_fail++; $display("FAIL load_bready[%0d]: got %b expected 1", i, b_ready); end
            tick();
            exp_l = N'(1) << i;
            n_tests++;
            if ({load_bias_out, bias_scalar_out, staged_full} !== {exp_l, set_vals[i], 1'(i == 3)}) begin
                n_fail++;
                $display("FAIL load_strobe[%0d]: got %b/%h/%b expected %b/%h/%b", i, load_bias_out,
                         bias_scalar_out, staged_full, exp_l, set_vals[i], i == 3);
            end
        end
        b_data = 16'hDEAD;
        tick();
        n_tests++;
        if ({b_ready, load_bias_out, bias_scalar_out, staged_full} !== {1'b0, 4'b0000, 16'h0080, 1'b1}) begin
            n_fail++;
            $display("FAIL load_full_hold: got %b/%b/%h/%b expected 0/0000/0080/1", b_ready, load_bias_out,
                     bias_scalar_out, staged_full);
        end
        b_valid = 1'b0;
    endtask

    task automatic test_tile_run();
        tile_start = 1'b1; tile_rows = 8'd3; tile_backward = 1'b0;
        #1;
        n_tests++;
        if (tile_start_ready !== 1'b1) begin n_fail++; $display("FAIL run_tsr: got %b expected 1", tile_start_ready); end
        tick();
        tile_start = 1'b0;
        n_tests++;
        if ({bias_switch_out, running, staged_full, bias_backward_out, load_bias_out} !== {3'b110, 1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL run_switch: got sw=%b run=%b sf=%b bw=%b ld=%b expected 1/1/0/0/0000", bias_switch_out,
                     running, staged_full, bias_backward_out, load_bias_out);
        end
        for (int p = 0; p < 3; p++) begin
            col_valid_last_in = 1'b1;
            tick();
            col_valid_last_in = 1'b0;
            n_tests++;
            if ({bias_switch_out, tile_done, running} !== {1'b0, 1'(p == 2), 1'(p != 2)}) begin
                n_fail++;
                $display("FAIL run_beat[%0d]: got sw=%b done=%b run=%b expected 0/%b/%b", p, bias_switch_out,
                         tile_done, running, p == 2, p != 2);
            end
            if (p < 2) tick();
        end
        tick();
        n_tests++;
        if ({tile_done, running, err_out} !== 3'b000) begin
            n_fail++;
            $display("FAIL run_after: got done=%b run=%b err=%b expected 000", tile_done, running, err_out);
        end
    endtask

    task automatic test_back_to_back();
        set_vals[0] = 16'h1111; set_vals[1] = 16'h2222; set_vals[2] = 16'h3333; set_vals[3] = 16'h4444;
        load_set();
        tile_start = 1'b1; tile_rows = 8'd2; tile_backward = 1'b1;
        tick();
        tile_rows = 8'd0; tile_backward = 1'b0;
        n_tests++;
        if ({bias_switch_out, bias_backward_out, load_bias_out} !== {2'b11, 4'b0000}) begin
            n_fail++;
            $display("FAIL bwd_switch: got sw=%b bw=%b ld=%b expected 1/1/0000", bias_switch_out,
                     bias_backward_out, load_bias_out);
        end
        for (int i = 0; i < 4; i++) begin
            b_valid = 1'b1;
            b_data  = 16'h5000 + DW'(i);
            tick();
            n_tests++;
            if ({bias_backward_out, running, load_bias_out} !== {2'b11, 4'(N'(1) << i)}) begin
                n_fail++;
                $display("FAIL overlap_load[%0d]: got bw=%b run=%b ld=%b", i, bias_backward_out, running, load_bias_out);
            end
        end
        b_valid = 1'b0;
        n_tests++;
        if ({staged_full, tile_start_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL overlap_staged: got sf=%b tsr=%b expected 1/0", staged_full, tile_start_ready);
        end
        col_valid_last_in = 1'b1;
        tick();
        col_valid_last_in = 1'b0;
        n_tests++;
        if ({bias_backward_out, tile_done} !== 2'b10) begin
            n_fail++;
            $display("FAIL bwd_beat1: got bw=%b done=%b expected 1/0", bias_backward_out, tile_done);
        end
        tick();
        col_valid_last_in = 1'b1;
        tick();
        col_valid_last_in = 1'b0;
        b_valid = 1'b1;
        b_data  = 16'h1234;
        #1;
        n_tests++;
        if ({tile_done, bias_backward_out, running, bias_switch_out, tile_start_ready, b_ready} !== 6'b100010) begin
            n_fail++;
            $display("FAIL b2b_done: got done=%b bw=%b run=%b sw=%b tsr=%b rdy=%b expected 1/0/0/0/1/0", tile_done,
                     bias_backward_out, running, bias_switch_out, tile_start_ready, b_ready);
        end
        tick();
        tile_start = 1'b0;
        n_tests++;
        if ({bias_switch_out, load_bias_out, running, bias_backward_out, tile_done} !== {1'b1, 4'b0000, 3'b100}) begin
            n_fail++;
            $display("FAIL b2b_switch: got sw=%b ld=%b run=%b bw=%b done=%b expected 1/0000/1/0/0", bias_switch_out,
                     load_bias_out, running, bias_backward_out, tile_done);
        end
        tick();
        b_valid = 1'b0;
        n_tests++;
        if ({tile_done, running, bias_switch_out, load_bias_out, bias_scalar_out} !== {3'b100, 4'b0001, 16'h1234}) begin
            n_fail++;
            $display("FAIL rows0_done: got done=%b run=%b sw=%b ld=%b d=%h expected 1/0/0/0001/1234", tile_done,
                     running, bias_switch_out, load_bias_out, bias_scalar_out);
        end
    endtask

    task automatic test_edge();
        do_reset();
        col_valid_last_in = 1'b1;
        tick();
        col_valid_last_in = 1'b0;
        n_tests++;
        if (err_out !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err_out); end
        tick(); tick(); tick();
        n_tests++;
        if (err_out !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err_out); end
        tile_start = 1'b1; tile_rows = 8'd1;
        #1;
        n_tests++;
        if (tile_start_ready !== 1'b0) begin n_fail++; $display("FAIL empty_tsr: got %b expected 0", tile_start_ready); end
        tick();
        tile_start = 1'b0;
        n_tests++;
        if ({bias_switch_out, running} !== 2'b00) begin
            n_fail++;
            $display("FAIL empty_noswitch: got sw=%b run=%b expected 0/0", bias_switch_out, running);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_vals[0] = 16'h0A01; set_vals[1] = 16'h0A02; set_vals[2] = 16'h0A03; set_vals[3] = 16'h0A04;
        for (int i = 0; i < 2; i++) begin
            b_valid = 1'b1; b_data = set_vals[i]; tick();
        end
        b_valid = 1'b0;
        rst = 1'b1;
        tick();
        n_tests++;
        if (all_outs !== '0) begin n_fail++; $display("FAIL rst_midload: got %h expected 0", all_outs); end
        rst = 1'b0;
        b_valid = 1'b1; b_data = 16'h0AAA;
        tick();
        b_valid = 1'b0;
        n_tests++;
        if ({load_bias_out, bias_scalar_out} !== {4'b0001, 16'h0AAA}) begin
            n_fail++;
            $display("FAIL rst_restart_load: got %b/%h expected 0001/0aaa", load_bias_out, bias_scalar_out);
        end
        do_reset();
        load_set();
        tile_start = 1'b1; tile_rows = 8'd5; tile_backward = 1'b1;
        tick();
        tile_start = 1'b0;
        col_valid_last_in = 1'b1;
        tick();
        col_valid_last_in = 1'b0;
        n_tests++;
        if ({running, bias_backward_out} !== 2'b11) begin
            n_fail++;
            $display("FAIL midtile_pre: got run=%b bw=%b expected 1/1", running, bias_backward_out);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (all_outs !== '0) begin n_fail++; $display("FAIL rst_midtile: got %h expected 0", all_outs); end
        rst = 1'b0;
        b_valid = 1'b1; b_data = 16'h0BBB;
        tick();
        b_valid = 1'b0;
        n_tests++;
        if ({load_bias_out, running, tile_done} !== {4'b0001, 2'b00}) begin
            n_fail++;
            $display("FAIL rst_midtile_restart: got ld=%b run=%b done=%b expected 0001/0/0", load_bias_out,
                     running, tile_done);
        end
    endtask

    // Model: number of staged beats, whether a tile runs, rows still owed, sticky error.
    task automatic test_random();
        int            m_loaded;
        int            m_rem;
        bit            m_run, m_bw, m_switch, m_done, m_err, acc, exp_tsr, exp_rdy;
        logic [N-1:0]  m_load;
        logic [DW-1:0] m_scalar;
        do_reset();
        m_loaded = 0; m_rem = 0; m_run = 0; m_bw = 0; m_switch = 0; m_done = 0; m_err = 0;
        m_load = '0; m_scalar = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            rst               = ($urandom_range(0, 199) == 0);
            b_valid           = 1'($urandom_range(0, 1));
            b_data            = DW'($urandom);
            tile_start        = ($urandom_range(0, 3) != 0);
            tile_rows         = RW'($urandom_range(0, 4));
            tile_backward     = 1'($urandom_range(0, 1));
            col_valid_last_in = m_run ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 59) == 0);
            #1;
            exp_tsr = (m_loaded == N) && !m_run;
            acc     = tile_start && exp_tsr && !rst;
            exp_rdy = !rst && (m_loaded < N) && !acc;
            n_tests++;
            if ({b_ready, tile_start_ready} !== {exp_rdy, exp_tsr}) begin
                n_fail++;
                $display("FAIL rand_hs[%0d]: got rdy=%b tsr=%b expected %b/%b", cyc, b_ready, tile_start_ready,
                         exp_rdy, exp_tsr);
            end
            if (rst) begin
                m_loaded = 0; m_rem = 0; m_run = 0; m_bw = 0; m_switch = 0; m_done = 0; m_err = 0;
                m_load = '0; m_scalar = '0;
            end else begin
                m_load = '0;
                if (b_valid && exp_rdy) begin
                    m_load   = N'(1) << m_loaded;
                    m_scalar = b_data;
                    m_loaded++;
                end
                if (acc) m_loaded = 0;
                m_switch = acc;
                m_done   = 0;
                if (!m_run && col_valid_last_in) m_err = 1;
                if (acc) begin
                    m_run = 1; m_rem = int'(tile_rows); m_bw = tile_backward;
                end else if (m_run) begin
                    if (m_rem > 0 && col_valid_last_in) m_rem--;
                    if (m_rem == 0) begin
                        m_done = 1; m_run = 0; m_bw = 0;
                    end
                end
            end
            tick();
            n_tests++;
            if ({load_bias_out, bias_scalar_out, bias_switch_out, bias_backward_out, staged_full, running,
                 tile_done, err_out} !== {m_load, m_scalar, m_switch, m_bw, 1'(m_loaded == N), m_run, m_done, m_err}) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: got ld=%b d=%h sw=%b bw=%b sf=%b run=%b done=%b err=%b expected %b/%h/%b/%b/%b/%b/%b/%b",
                         cyc, load_bias_out, bias_scalar_out, bias_switch_out, bias_backward_out, staged_full,
                         running, tile_done, err_out, m_load, m_scalar, m_switch, m_bw, m_loaded == N, m_run,
                         m_done, m_err);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_load();
        test_tile_run();
        test_back_to_back();
        test_edge();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
